// File: rtl/frame_buf_sched_pkg.sv
// Shared encodings for the frame buffer scheduler: per-buffer states and the
// writer/reader FSM states.
package frame_buf_sched_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } buf_state_e;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_e;

endpackage

// File: rtl/frame_buf_sched_if.sv
// Frame-level handshake and buffer-bank port bundle for frame_buf_sched.
// master = frame source/sink side, slave = the scheduler.
interface frame_buf_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int BUF_W      = 2
);
    logic                  wr_frame_start;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_frame_req;
    logic                  rd_ready;

    logic                  mem_wr_en_n;
    logic [BUF_W-1:0]      mem_wr_sel;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en_n;
    logic [BUF_W-1:0]      mem_rd_sel;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic                  frame_avail;
    logic                  rd_frame_done;
    logic                  wr_drop;
    logic                  wr_busy;

    modport master (
        output wr_frame_start, wr_valid, data_in, rd_frame_req, rd_ready,
        input  mem_wr_en_n, mem_wr_sel, mem_wr_addr, mem_wr_data,
        input  mem_rd_en_n, mem_rd_sel, mem_rd_addr,
        input  frame_avail, rd_frame_done, wr_drop, wr_busy
    );

    modport slave (
        input  wr_frame_start, wr_valid, data_in, rd_frame_req, rd_ready,
        output mem_wr_en_n, mem_wr_sel, mem_wr_addr, mem_wr_data,
        output mem_rd_en_n, mem_rd_sel, mem_rd_addr,
        output frame_avail, rd_frame_done, wr_drop, wr_busy
    );
endinterface

// File: rtl/frame_buf_sched_alloc.sv
// fb_alloc: combinational priority allocator. Picks the lowest FREE buffer,
// else the lowest READY buffer that is not the newest frame, else the newest
// frame itself. Taking any READY buffer flags a drop.
module fb_alloc
    import frame_buf_sched_pkg::*;
#(
    parameter int NUM_BUFS = 2,
    parameter int BUF_W    = 2
) (
    input  logic [2*NUM_BUFS-1:0] states,
    input  logic [BUF_W-1:0]      last_ready,
    output logic [BUF_W-1:0]      alloc_idx,
    output logic                  alloc_valid,
    output logic                  alloc_drop
);
    logic [BUF_W-1:0] free_idx;
    logic [BUF_W-1:0] old_idx;
    logic             free_hit;
    logic             old_hit;
    logic             newest_ready;

    // Scan from the top down so the lowest matching index wins
    always_comb begin
        free_idx     = '0;
        free_hit     = 1'b0;
        old_idx      = '0;
        old_hit      = 1'b0;
        newest_ready = 1'b0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (states[2*i +: 2] == FREE) begin
                free_idx = BUF_W'(i);
                free_hit = 1'b1;
            end
            if (states[2*i +: 2] == READY) begin
                if (BUF_W'(i) == last_ready) begin
                    newest_ready = 1'b1;
                end else begin
                    old_idx = BUF_W'(i);
                    old_hit = 1'b1;
                end
            end
        end
    end

    // Prefer a free buffer, then a stale frame, and only then the newest frame
    always_comb begin
        alloc_idx   = free_idx;
        alloc_valid = 1'b1;
        alloc_drop  = 1'b0;
        if (!free_hit) begin
            if (old_hit) begin
                alloc_idx  = old_idx;
                alloc_drop = 1'b1;
            end else if (newest_ready) begin
                alloc_idx  = last_ready;
                alloc_drop = 1'b1;
            end else begin
                alloc_valid = 1'b0;
            end
        end
    end
endmodule

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: schedules NUM_BUFS frame buffers between one writer and
// one reader. Writer fills a free (or recycled) buffer; reader always gets
// the newest committed frame. Optional statistics counters are built when
// FB_SCHED_STATS_EN is defined.
module frame_buf_sched
    import frame_buf_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int FRAME_WORDS = 1 << ADDR_WIDTH,
    parameter int NUM_BUFS    = 2,
    parameter int BUF_W       = 2
) (
    input  logic              wr_clk,
    input  logic              reset,
    frame_buf_sched_if.slave  bus
`ifdef FB_SCHED_STATS_EN
    ,
    output logic [15:0]       drop_count,
    output logic [15:0]       busy_count
`endif
);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(FRAME_WORDS - 1);

    buf_state_e            buf_state [NUM_BUFS];
    logic [2*NUM_BUFS-1:0] state_vec;
    logic                  any_ready;
    logic                  newest_ready;
    logic [BUF_W-1:0]      last_ready;

    wr_state_e             w_state;
    logic [ADDR_WIDTH-1:0] wcnt;
    logic [BUF_W-1:0]      w_sel;
    rd_state_e             r_state;
    logic [ADDR_WIDTH-1:0] rcnt;
    logic [BUF_W-1:0]      r_sel;

    logic [BUF_W-1:0]      alloc_idx;
    logic                  alloc_valid;
    logic                  alloc_drop;
    logic                  wr_alloc, wr_commit, rd_lock, rd_release;

    logic                  wr_en_n_q, rd_en_n_q;
    logic [BUF_W-1:0]      wr_sel_q, rd_sel_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  avail_q, done_q, drop_q, busy_q;

    // Flatten buffer states for the allocator and summarise READY buffers
    always_comb begin
        state_vec    = '0;
        any_ready    = 1'b0;
        newest_ready = 1'b0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            state_vec[2*i +: 2] = buf_state[i];
            if (buf_state[i] == READY) begin
                any_ready = 1'b1;
                if (BUF_W'(i) == last_ready) newest_ready = 1'b1;
            end
        end
    end

    fb_alloc #(.NUM_BUFS(NUM_BUFS), .BUF_W(BUF_W)) u_alloc (
        .states      (state_vec),
        .last_ready  (last_ready),
        .alloc_idx   (alloc_idx),
        .alloc_valid (alloc_valid),
        .alloc_drop  (alloc_drop)
    );

    // The newest_ready guard stops a lagging frame_avail from locking a
    // buffer that was just recycled or released.
    assign wr_alloc   = (w_state == W_IDLE) && bus.wr_frame_start && alloc_valid;
    assign wr_commit  = (w_state == W_FILL) && bus.wr_valid && (wcnt == LAST_WORD);
    assign rd_lock    = (r_state == R_IDLE) && bus.rd_frame_req && avail_q && newest_ready;
    assign rd_release = (r_state == R_READ) && bus.rd_ready && (rcnt == LAST_WORD);

    // Buffer ownership transitions; the four events never target the same buffer
    always_ff @(posedge wr_clk) begin
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (reset) begin
                buf_state[i] <= FREE;
            end else begin
                if (wr_alloc   && alloc_idx  == BUF_W'(i)) buf_state[i] <= WRITING;
                if (wr_commit  && w_sel      == BUF_W'(i)) buf_state[i] <= READY;
                if (rd_lock    && last_ready == BUF_W'(i)) buf_state[i] <= READING;
                if (rd_release && r_sel      == BUF_W'(i)) buf_state[i] <= FREE;
            end
        end
    end

    // Writer FSM: allocate on frame start, then issue one write per valid word
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            w_state    <= W_IDLE;
            wcnt       <= '0;
            w_sel      <= '0;
            last_ready <= '0;
            wr_en_n_q  <= 1'b1;
            wr_sel_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            drop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_en_n_q <= 1'b1;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    if (bus.wr_frame_start) begin
                        if (alloc_valid) begin
                            w_sel   <= alloc_idx;
                            wcnt    <= '0;
                            drop_q  <= alloc_drop;
                            w_state <= W_FILL;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                end
                W_FILL: begin
                    if (bus.wr_valid) begin
                        wr_en_n_q <= 1'b0;
                        wr_sel_q  <= w_sel;
                        wr_addr_q <= wcnt;
                        wr_data_q <= bus.data_in;
                        if (wcnt == LAST_WORD) begin
                            wcnt       <= '0;
                            last_ready <= w_sel;
                            w_state    <= W_IDLE;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Reader FSM: lock the newest frame, then issue one read per ready cycle
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            rcnt      <= '0;
            r_sel     <= '0;
            rd_en_n_q <= 1'b1;
            rd_sel_q  <= '0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            rd_en_n_q <= 1'b1;
            done_q    <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (rd_lock) begin
                        r_sel   <= last_ready;
                        rcnt    <= '0;
                        r_state <= R_READ;
                    end
                end
                R_READ: begin
                    if (bus.rd_ready) begin
                        rd_en_n_q <= 1'b0;
                        rd_sel_q  <= r_sel;
                        rd_addr_q <= rcnt;
                        if (rcnt == LAST_WORD) begin
                            rcnt    <= '0;
                            done_q  <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // frame_avail lags the buffer states by one cycle
    always_ff @(posedge wr_clk) begin
        if (reset) avail_q <= 1'b0;
        else       avail_q <= any_ready;
    end

`ifdef FB_SCHED_STATS_EN
    // Saturating drop/busy event counters
    always_ff @(posedge wr_clk) begin
        if (reset) begin
            drop_count <= '0;
            busy_count <= '0;
        end else begin
            if (drop_q && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
            if (busy_q && busy_count != 16'hFFFF) busy_count <= busy_count + 1'b1;
        end
    end
`endif

    assign bus.mem_wr_en_n   = wr_en_n_q;
    assign bus.mem_wr_sel    = wr_sel_q;
    assign bus.mem_wr_addr   = wr_addr_q;
    assign bus.mem_wr_data   = wr_data_q;
    assign bus.mem_rd_en_n   = rd_en_n_q;
    assign bus.mem_rd_sel    = rd_sel_q;
    assign bus.mem_rd_addr   = rd_addr_q;
    assign bus.frame_avail   = avail_q;
    assign bus.rd_frame_done = done_q;
    assign bus.wr_drop       = drop_q;
    assign bus.wr_busy       = busy_q;
endmodule
